// File: rtl/bus_sram_slave.sv
// bus_sram_slave: 32-bit SRAM window on a begin/end burst bus.
// Reads use a one-cycle synchronous RAM; writes accept beats under byte enables.
module bus_sram_slave #(
    parameter logic [31:0] baseAddress   = 32'h40000000,
    parameter int          wordDepthLog2 = 10,
    parameter int          waitStates    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        beginTransactionIn,
    input  logic        endTransactionIn,
    input  logic        readNotWriteIn,
    input  logic        dataValidIn,
    input  logic        busyIn,
    input  logic [31:0] addressDataIn,
    input  logic [3:0]  byteEnablesIn,
    input  logic [7:0]  burstSizeIn,
    output logic        endTransactionOut,
    output logic        dataValidOut,
    output logic        busyOut,
    output logic        busErrorOut,
    output logic [31:0] addressDataOut
);
    localparam int                       DEPTH     = 1 << wordDepthLog2;
    localparam logic [3:0]               WAIT_LOAD = 4'(waitStates);
    localparam logic [wordDepthLog2-1:0] IDX_ONE   = 1;

    typedef enum logic [2:0] {IDLE, WAIT, READ, WRITE, END, ERROR} state_t;

    state_t                   state, next_state;
    logic [wordDepthLog2-1:0] index;      // next word to fetch (read) or write
    logic [8:0]               count;      // beats still owed, 1..256 at start
    logic [3:0]               wait_cnt;
    logic                     is_read;
    logic                     data_valid;
    logic [31:0]              read_data;
    logic [31:0]              mem [DEPTH];

    logic select, fetch, beat_done, mem_we;

    assign select = beginTransactionIn &&
                    (addressDataIn[31:wordDepthLog2+2] == baseAddress[31:wordDepthLog2+2]);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state and per-cycle memory controls
    always_comb begin
        next_state = state;
        fetch      = 1'b0;
        beat_done  = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (select) begin
                    if (addressDataIn[1:0] != 2'b00) next_state = ERROR;
                    else if (waitStates > 0)        next_state = WAIT;
                    else if (readNotWriteIn)        next_state = READ;
                    else                            next_state = WRITE;
                end
            end
            WAIT: begin
                if (endTransactionIn)       next_state = IDLE;
                else if (wait_cnt == 4'd1)  next_state = is_read ? READ : WRITE;
            end
            READ: begin
                if (endTransactionIn) begin
                    next_state = IDLE;
                end else if (!data_valid) begin
                    fetch = 1'b1;                 // prime the first beat
                end else if (!busyIn) begin
                    beat_done = 1'b1;
                    if (count == 9'd1) next_state = END;
                    else               fetch = 1'b1;
                end
            end
            WRITE: begin
                mem_we = dataValidIn && (count != 9'd0);
                if (endTransactionIn) next_state = IDLE;
            end
            END:     next_state = IDLE;
            ERROR:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Transaction context: index, remaining beats, wait timer, read valid
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            index      <= '0;
            count      <= '0;
            wait_cnt   <= '0;
            is_read    <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            if (state == IDLE && select) begin
                index    <= addressDataIn[wordDepthLog2+1:2];
                count    <= {1'b0, burstSizeIn} + 9'd1;
                is_read  <= readNotWriteIn;
                wait_cnt <= WAIT_LOAD;
            end
            if (state == WAIT)       wait_cnt <= wait_cnt - 4'd1;
            if (fetch || mem_we)     index <= index + IDX_ONE;
            if (beat_done || mem_we) count <= count - 9'd1;
            // A beat stays presented while busy; it is replaced only by a new fetch
            data_valid <= (next_state == READ) && (fetch || data_valid);
        end
    end

    // RAM array: byte-masked writes, registered reads, never cleared by reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (byteEnablesIn[b]) mem[index][8*b +: 8] <= addressDataIn[8*b +: 8];
        end
        if (fetch) read_data <= mem[index];
    end

    assign endTransactionOut = (state == END);
    assign busErrorOut       = (state == ERROR);
    assign busyOut           = (state == WAIT) && !is_read;
    assign dataValidOut      = data_valid;
    assign addressDataOut    = data_valid ? read_data : 32'h0;

endmodule

// File: tb/tb_bus_sram_slave.sv
// tb_bus_sram_slave: randomized bursts against an array model; read beats go
// through a scoreboard queue checked by an independent monitor.
module tb_bus_sram_slave;
    localparam logic [31:0] BASE  = 32'h40000000;
    localparam int          DLOG2 = 10;
    localparam int          DEPTH = 1 << DLOG2;
    localparam int          W     = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        beginTransactionIn, endTransactionIn, readNotWriteIn;
    logic        dataValidIn, busyIn;
    logic [31:0] addressDataIn;
    logic [3:0]  byteEnablesIn;
    logic [7:0]  burstSizeIn;
    logic        endTransactionOut, dataValidOut, busyOut, busErrorOut;
    logic [31:0] addressDataOut;

    int tests = 0, fails = 0;
    int obs_end = 0, obs_err = 0, obs_busy = 0, obs_dv = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_q[$];
    logic [31:0] wdata_q[$];

    bus_sram_slave #(
        .baseAddress(BASE), .wordDepthLog2(DLOG2), .waitStates(W)
    ) dut (
        .clock(clock), .reset(reset),
        .beginTransactionIn(beginTransactionIn), .endTransactionIn(endTransactionIn),
        .readNotWriteIn(readNotWriteIn), .dataValidIn(dataValidIn), .busyIn(busyIn),
        .addressDataIn(addressDataIn), .byteEnablesIn(byteEnablesIn),
        .burstSizeIn(burstSizeIn), .endTransactionOut(endTransactionOut),
        .dataValidOut(dataValidOut), .busyOut(busyOut), .busErrorOut(busErrorOut),
        .addressDataOut(addressDataOut)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    // Monitor: compares every presented read beat against the scoreboard head
    always @(negedge clock) begin
        if (!reset) begin
            if (dataValidOut) begin
                obs_dv++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got %0h, expected no beat", addressDataOut);
                end else begin
                    check("read_data", addressDataOut, exp_q[0]);
                    if (!busyIn) void'(exp_q.pop_front());
                end
                check("dv_exclusive", {endTransactionOut, busErrorOut}, 0);
            end else begin
                check("idle_data_zero", addressDataOut, 0);
            end
            if (endTransactionOut) begin
                obs_end++;
                check("end_all_beats_done", exp_q.size(), 0);
                check("end_exclusive", busErrorOut, 0);
            end
            if (busErrorOut) obs_err++;
            if (busyOut)     obs_busy++;
        end
    end

    task automatic begin_txn(input logic [31:0] addr, input logic rnw, input int burst);
        beginTransactionIn = 1'b1;
        addressDataIn      = addr;
        readNotWriteIn     = rnw;
        burstSizeIn        = 8'(burst);
        tick();
        beginTransactionIn = 1'b0;
        readNotWriteIn     = 1'b0;
        addressDataIn      = '0;
    endtask

    task automatic write_burst(input logic [31:0] addr, input int burst, input logic [3:0] be,
                               input int extra, input bit poke);
        int idx, busy0, nbeats;
        logic [31:0] d;
        idx = word_of(addr);
        busy0 = obs_busy;
        nbeats = burst + 1 + extra;
        begin_txn(addr, 1'b0, burst);
        repeat (W) tick();
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(3) == 0) begin
                dataValidIn = 1'b0;
                tick();
            end
            d = (wdata_q.size() > 0) ? wdata_q.pop_front() : $urandom;
            dataValidIn   = 1'b1;
            addressDataIn = d;
            byteEnablesIn = be;
            if (poke && i == 0) begin
                beginTransactionIn = 1'b1;
                readNotWriteIn     = 1'b1;
            end
            if (i <= burst) model_write((idx + i) % DEPTH, d, be);
            endTransactionIn = (i == nbeats - 1);
            tick();
            beginTransactionIn = 1'b0;
            readNotWriteIn     = 1'b0;
        end
        dataValidIn = 1'b0; endTransactionIn = 1'b0; addressDataIn = '0; byteEnablesIn = '0;
        tick();
        check("write_busy_cycles", obs_busy - busy0, W);
    endtask

    // busy_mode: 0 never busy, 1 random 30%, 2 busy on the first two data cycles
    task automatic read_burst(input logic [31:0] addr, input int burst, input int busy_mode);
        int idx, end0, busy0, k;
        idx = word_of(addr);
        end0 = obs_end;
        busy0 = obs_busy;
        for (int i = 0; i <= burst; i++) exp_q.push_back(model_mem[(idx + i) % DEPTH]);
        begin_txn(addr, 1'b1, burst);
        for (int c = 1; c <= W + 1; c++) begin
            @(negedge clock);
            check("pre_first_valid", dataValidOut, 0);
            tick();
        end
        k = 0;
        busyIn = (busy_mode == 2) ? 1'b1 : (busy_mode == 1) ? ($urandom_range(99) < 30) : 1'b0;
        @(negedge clock);
        check("first_valid_timing", dataValidOut, 1);
        tick();
        k++;
        while (obs_end == end0 && k < 3000) begin
            busyIn = (busy_mode == 2) ? (k < 2) : (busy_mode == 1) ? ($urandom_range(99) < 30) : 1'b0;
            tick();
            k++;
        end
        busyIn = 1'b0;
        repeat (2) tick();
        check("read_end_pulses", obs_end - end0, 1);
        check("read_busy_zero", obs_busy - busy0, 0);
        exp_q.delete();
    endtask

    task automatic abort_read(input logic [31:0] addr, input int burst, input int n);
        int idx, end0;
        idx = word_of(addr);
        end0 = obs_end;
        for (int i = 0; i <= burst; i++) exp_q.push_back(model_mem[(idx + i) % DEPTH]);
        begin_txn(addr, 1'b1, burst);
        repeat (n) tick();
        endTransactionIn = 1'b1;
        tick();
        endTransactionIn = 1'b0;
        exp_q.delete();
        repeat (4) tick();
        check("abort_no_end", obs_end - end0, 0);
    endtask

    task automatic err_begin(input logic [31:0] addr);
        int err0;
        err0 = obs_err;
        begin_txn(addr, 1'($urandom_range(1)), $urandom_range(7));
        @(negedge clock);
        check("err_pulse", busErrorOut, 1);
        tick();
        @(negedge clock);
        check("err_one_cycle", busErrorOut, 0);
        tick();
        check("err_count", obs_err - err0, 1);
    endtask

    initial begin
        logic [31:0] a;
        int burst, r;
        beginTransactionIn = 0; endTransactionIn = 0; readNotWriteIn = 0;
        dataValidIn = 0; busyIn = 0; addressDataIn = '0; byteEnablesIn = '0; burstSizeIn = '0;
        reset = 1'b1;
        repeat (3) tick();
        check("reset_outputs", {endTransactionOut, dataValidOut, busyOut, busErrorOut, addressDataOut}, 0);
        reset = 1'b0;
        tick();

        // Fill the whole window so every later read has a known expectation
        for (int k = 0; k < DEPTH / 256; k++) write_burst(BASE + 32'(k * 1024), 255, 4'hF, 0, 0);

        // Four-word write and read back at word 4
        wdata_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        write_burst(BASE + 32'h10, 3, 4'hF, 0, 0);
        read_burst(BASE + 32'h10, 3, 0);

        // Beat 0 held by busy for two cycles
        begin
            int dv0;
            dv0 = obs_dv;
            read_burst(BASE + 32'h40, 1, 2);
            check("busy_hold_dv_cycles", obs_dv - dv0, 4);
        end

        // Misaligned begin, then a normal read of the untouched word
        err_begin(BASE + 32'h2);
        read_burst(BASE, 0, 0);

        // Wrap from the last word back to word 0
        read_burst(BASE + 32'hFFC, 1, 0);
        write_burst(BASE + 32'hFF8, 3, 4'hF, 0, 0);
        read_burst(BASE + 32'hFF8, 3, 1);

        // Byte enables 0101 over a zero word
        wdata_q = '{32'h0};
        write_burst(BASE, 0, 4'hF, 0, 0);
        wdata_q = '{32'hAABBCCDD};
        write_burst(BASE, 0, 4'b0101, 0, 0);
        read_burst(BASE, 0, 0);

        // Out-of-window begins: no activity, nothing written
        begin_txn(32'h50000000, 1'b1, 3);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("nonselect_quiet", {endTransactionOut, dataValidOut, busyOut, busErrorOut, addressDataOut}, 0);
            tick();
        end
        begin_txn(32'h50000000, 1'b0, 0);
        dataValidIn = 1'b1; addressDataIn = 32'hDEADBEEF; byteEnablesIn = 4'hF;
        tick();
        dataValidIn = 1'b0; addressDataIn = '0; byteEnablesIn = '0;
        tick();
        read_burst(BASE, 0, 0);

        // Write aborted in WAIT: following beats must not land
        begin_txn(BASE + 32'h80, 1'b0, 3);
        endTransactionIn = 1'b1;
        tick();
        endTransactionIn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            dataValidIn = 1'b1; addressDataIn = $urandom; byteEnablesIn = 4'hF;
            tick();
        end
        dataValidIn = 1'b0; addressDataIn = '0; byteEnablesIn = '0;
        tick();
        read_burst(BASE + 32'h80, 3, 0);

        // Extra beats past the count, begin poke mid-write
        write_burst(BASE + 32'h100, 2, 4'hF, 3, 1);
        read_burst(BASE + 32'h100, 5, 1);

        // Reset during beat 2 of an 8-beat read
        for (int i = 0; i < 8; i++) exp_q.push_back(model_mem[(word_of(BASE + 32'h300) + i) % DEPTH]);
        begin_txn(BASE + 32'h300, 1'b1, 7);
        repeat (W + 3) tick();
        #1;
        check("beat2_present", dataValidOut, 1);
        reset = 1'b1;
        #1;
        check("reset_mid_read", {endTransactionOut, dataValidOut, busyOut, busErrorOut, addressDataOut}, 0);
        tick();
        exp_q.delete();
        reset = 1'b0;
        tick();
        read_burst(BASE + 32'h300, 5, 1);

        // Reset during a write keeps the first three beats only
        begin_txn(BASE + 32'h200, 1'b0, 7);
        repeat (W) tick();
        for (int i = 0; i < 3; i++) begin
            dataValidIn = 1'b1; addressDataIn = $urandom; byteEnablesIn = 4'hF;
            model_write(word_of(BASE + 32'h200) + i, addressDataIn, 4'hF);
            tick();
        end
        addressDataIn = $urandom;
        #1;
        reset = 1'b1;
        #1;
        check("reset_mid_write", {endTransactionOut, dataValidOut, busyOut, busErrorOut, addressDataOut}, 0);
        tick();
        dataValidIn = 1'b0; addressDataIn = '0; byteEnablesIn = '0;
        reset = 1'b0;
        tick();
        read_burst(BASE + 32'h200, 7, 0);

        // Randomized mix
        for (int it = 0; it < 30; it++) begin
            r = $urandom_range(9);
            a = BASE | (32'($urandom_range(DEPTH - 1)) << 2);
            burst = $urandom_range(15);
            if (r < 4)       write_burst(a, burst, 4'($urandom_range(15)), $urandom_range(2), r == 0);
            else if (r < 8)  read_burst(a, burst, 1);
            else if (r == 8) abort_read(a, burst, $urandom_range(1, W + 1 + burst));
            else             err_begin(a | 32'($urandom_range(1, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        fails++;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
